dbg_cmd_master: RTL and testbench

Host-side command master driving the debug register slave's TileLink-UL A/D channels. Accepts framed byte commands from a host byte stream (UART/JTAG shim), issues one PutFullData or Get per command, waits for the D response, and returns a status byte (plus read data) on an outgoing byte stream. Exactly one transaction is in flight at a time.

---
 rtl/dbg_cmd_master.sv | 197 +++++++++++++++++++
 tb/tb_dbg_cmd_master.sv | 566 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dbg_cmd_master
// Purpose  : Host-side command master for the debug register slave. Takes
//            framed byte commands from a host byte stream, issues a single
//            TileLink-UL PutFullData or Get on the A channel, waits for the
//            D response and returns a status byte (plus read data) to the
//            host. Only one transaction is in flight at any time.
// Ports    : debug_clock_i / debug_resetn_i      clock, async active-low reset
//            host_rx_*                           command byte stream in
//            host_tx_*                           response byte stream out
//            debug_a_*                           TL-UL A channel (request)
//            debug_d_*                           TL-UL D channel (response)
//            busy_o                              high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module dbg_cmd_master #(
  parameter int unsigned TL_RS     = 4,
  parameter int unsigned SOURCE_ID = 0
) (
  input  logic             debug_clock_i,
  input  logic             debug_resetn_i,
  input  logic [7:0]       host_rx_data,
  input  logic             host_rx_valid,
  output logic             host_rx_ready,
  output logic [7:0]       host_tx_data,
  output logic             host_tx_valid,
  input  logic             host_tx_ready,
  output logic [2:0]       debug_a_opcode,
  output logic [2:0]       debug_a_param,
  output logic [3:0]       debug_a_size,
  output logic [TL_RS-1:0] debug_a_source,
  output logic [4:0]       debug_a_address,
  output logic [3:0]       debug_a_mask,
  output logic [31:0]      debug_a_data,
  output logic             debug_a_corrupt,
  output logic             debug_a_valid,
  input  logic             debug_a_ready,
  input  logic [2:0]       debug_d_opcode,
  input  logic [1:0]       debug_d_param,
  input  logic [3:0]       debug_d_size,
  input  logic [TL_RS-1:0] debug_d_source,
  input  logic             debug_d_denied,
  input  logic [31:0]      debug_d_data,
  input  logic             debug_d_corrupt,
  input  logic             debug_d_valid,
  output logic             debug_d_ready,
  output logic             busy_o
);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [3:0] SIZE_WORD   = 4'd2;
  localparam logic [7:0] ST_OK       = 8'hA5;
  localparam logic [7:0] ST_ERR      = 8'hE5;
  localparam logic [7:0] ST_BADCMD   = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_REQ  = 3'd2,
    S_RESP = 3'd3,
    S_TX   = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;   // write data bytes already received
  logic        is_read;    // current command returns read data
  logic [31:0] rdata;      // captured D data, shifted out LSB first
  logic [2:0]  tx_left;    // response bytes still to send after the current one

  // D-channel header fields carry nothing this block needs.
  logic unused_d_fields;
  assign unused_d_fields = ^{debug_d_opcode, debug_d_param, debug_d_size, debug_d_source};

  assign debug_a_param   = 3'd0;
  assign debug_a_corrupt = 1'b0;

  always_ff @(posedge debug_clock_i or negedge debug_resetn_i) begin
    if (!debug_resetn_i) begin
      state           <= S_IDLE;
      host_rx_ready   <= 1'b0;
      host_tx_valid   <= 1'b0;
      host_tx_data    <= 8'd0;
      debug_a_valid   <= 1'b0;
      debug_a_opcode  <= 3'd0;
      debug_a_size    <= 4'd0;
      debug_a_source  <= '0;
      debug_a_address <= 5'd0;
      debug_a_mask    <= 4'd0;
      debug_a_data    <= 32'd0;
      debug_d_ready   <= 1'b0;
      busy_o          <= 1'b0;
      byte_cnt        <= 2'd0;
      is_read         <= 1'b0;
      rdata           <= 32'd0;
      tx_left         <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // Ready comes up one edge after reset release or TX completion.
          host_rx_ready <= 1'b1;
          if (host_rx_ready && host_rx_valid) begin
            case (host_rx_data[7:6])
              2'b00: begin
                state           <= S_DATA;
                byte_cnt        <= 2'd0;
                is_read         <= 1'b0;
                busy_o          <= 1'b1;
                debug_a_address <= host_rx_data[4:0];
                debug_a_opcode  <= OP_PUT_FULL;
              end
              2'b01: begin
                state           <= S_REQ;
                is_read         <= 1'b1;
                busy_o          <= 1'b1;
                host_rx_ready   <= 1'b0;
                debug_a_valid   <= 1'b1;
                debug_a_address <= host_rx_data[4:0];
                debug_a_opcode  <= OP_GET;
                debug_a_data    <= 32'd0;
                debug_a_size    <= SIZE_WORD;
                debug_a_mask    <= 4'hF;
                debug_a_source  <= TL_RS'(SOURCE_ID);
              end
              default: begin
                // Reserved command: answer with an error byte, no bus access.
                state         <= S_TX;
                is_read       <= 1'b0;
                busy_o        <= 1'b1;
                host_rx_ready <= 1'b0;
                host_tx_valid <= 1'b1;
                host_tx_data  <= ST_BADCMD;
                tx_left       <= 3'd0;
              end
            endcase
          end
        end

        S_DATA: begin
          if (host_rx_valid) begin
            // Little-endian: after four shifts the first byte sits in [7:0].
            debug_a_data <= {host_rx_data, debug_a_data[31:8]};
            byte_cnt     <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state          <= S_REQ;
              host_rx_ready  <= 1'b0;
              debug_a_valid  <= 1'b1;
              debug_a_size   <= SIZE_WORD;
              debug_a_mask   <= 4'hF;
              debug_a_source <= TL_RS'(SOURCE_ID);
            end
          end
        end

        S_REQ: begin
          if (debug_a_ready) begin
            state         <= S_RESP;
            debug_a_valid <= 1'b0;
            debug_d_ready <= 1'b1;
          end
        end

        S_RESP: begin
          if (debug_d_valid) begin
            state         <= S_TX;
            debug_d_ready <= 1'b0;
            rdata         <= debug_d_data;
            host_tx_valid <= 1'b1;
            host_tx_data  <= (debug_d_denied || debug_d_corrupt) ? ST_ERR : ST_OK;
            tx_left       <= is_read ? 3'd4 : 3'd0;
          end
        end

        S_TX: begin
          if (host_tx_ready) begin
            if (tx_left == 3'd0) begin
              state         <= S_IDLE;
              host_tx_valid <= 1'b0;
              host_rx_ready <= 1'b1;
              busy_o        <= 1'b0;
            end else begin
              host_tx_data <= rdata[7:0];
              rdata        <= {8'd0, rdata[31:8]};
              tx_left      <= tx_left - 3'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbg_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dbg_cmd_master
// Purpose  : Self-checking bench for dbg_cmd_master. Acts as host and as the
//            TL-UL slave, compares observed bus/stream behaviour against a
//            byte-level reference model of the command protocol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbg_cmd_master;

  localparam int TL_RS     = 4;
  localparam int SOURCE_ID = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       host_rx_data = 8'd0;
  logic             host_rx_valid = 1'b0;
  logic             host_rx_ready;
  logic [7:0]       host_tx_data;
  logic             host_tx_valid;
  logic             host_tx_ready = 1'b0;
  logic [2:0]       debug_a_opcode;
  logic [2:0]       debug_a_param;
  logic [3:0]       debug_a_size;
  logic [TL_RS-1:0] debug_a_source;
  logic [4:0]       debug_a_address;
  logic [3:0]       debug_a_mask;
  logic [31:0]      debug_a_data;
  logic             debug_a_corrupt;
  logic             debug_a_valid;
  logic             debug_a_ready = 1'b0;
  logic [2:0]       debug_d_opcode = 3'd0;
  logic [1:0]       debug_d_param = 2'd0;
  logic [3:0]       debug_d_size = 4'd0;
  logic [TL_RS-1:0] debug_d_source = '0;
  logic             debug_d_denied = 1'b0;
  logic [31:0]      debug_d_data = 32'd0;
  logic             debug_d_corrupt = 1'b0;
  logic             debug_d_valid = 1'b0;
  logic             debug_d_ready;
  logic             busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dbg_cmd_master #(.TL_RS(TL_RS), .SOURCE_ID(SOURCE_ID)) dut (
    .debug_clock_i   (clk),
    .debug_resetn_i  (rst_n),
    .host_rx_data    (host_rx_data),
    .host_rx_valid   (host_rx_valid),
    .host_rx_ready   (host_rx_ready),
    .host_tx_data    (host_tx_data),
    .host_tx_valid   (host_tx_valid),
    .host_tx_ready   (host_tx_ready),
    .debug_a_opcode  (debug_a_opcode),
    .debug_a_param   (debug_a_param),
    .debug_a_size    (debug_a_size),
    .debug_a_source  (debug_a_source),
    .debug_a_address (debug_a_address),
    .debug_a_mask    (debug_a_mask),
    .debug_a_data    (debug_a_data),
    .debug_a_corrupt (debug_a_corrupt),
    .debug_a_valid   (debug_a_valid),
    .debug_a_ready   (debug_a_ready),
    .debug_d_opcode  (debug_d_opcode),
    .debug_d_param   (debug_d_param),
    .debug_d_size    (debug_d_size),
    .debug_d_source  (debug_d_source),
    .debug_d_denied  (debug_d_denied),
    .debug_d_data    (debug_d_data),
    .debug_d_corrupt (debug_d_corrupt),
    .debug_d_valid   (debug_d_valid),
    .debug_d_ready   (debug_d_ready),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Everything observed during one command, judged afterwards by each test.
  typedef struct packed {
    bit          timeout;
    bit          a_pulse;
    bit          a_unstable;
    bit          a_valid_after;
    bit          d_ready_after_a;
    bit          d_ready_after_d;
    bit          rx_leak;
    bit          busy_bad;
    bit          tx_gap;
    bit          tx_unstable;
    bit          busy_idle;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [3:0]  a_mask;
    logic [TL_RS-1:0] a_source;
    logic [4:0]  a_address;
    logic [31:0] a_data;
    logic        a_corrupt;
    int          tx_n;
    logic [39:0] tx_bytes;
    int          hs_stamp;
    int          a_stamp;
    int          tx_stamp;
    int          idle_stamp;
  } obs_t;

  // Reference model: the byte string the host should receive for a command.
  function automatic void model_tx(input logic [7:0] hdr, input logic [31:0] rd,
                                   input logic den, input logic cor,
                                   output int n, output logic [39:0] b);
    b = 40'd0;
    if (hdr[7]) begin
      n = 1;
      b[7:0] = 8'hEE;
    end else begin
      b[7:0] = (den || cor) ? 8'hE5 : 8'hA5;
      if (hdr[7:6] == 2'b01) begin
        n = 5;
        b[39:8] = rd;
      end else begin
        n = 1;
      end
    end
  endfunction

  // Host + slave driver for one complete command. Inputs change at clk+1.
  task automatic do_txn(input logic [7:0] hdr, input logic [31:0] wd, input logic [31:0] rd,
                        input logic den, input logic cor, input int a_dly, input int d_dly,
                        input bit tx_bp, output obs_t o);
    logic [7:0] bytes [5];
    int nb;
    int w;
    bit pend;
    bit got_first;
    logic [7:0] pdata;
    o = '0;
    nb = (hdr[7:6] == 2'b00) ? 5 : 1;
    bytes[0] = hdr;
    bytes[1] = wd[7:0];
    bytes[2] = wd[15:8];
    bytes[3] = wd[23:16];
    bytes[4] = wd[31:24];
    for (int i = 0; i < nb; i++) begin
      host_rx_valid = 1'b1;
      host_rx_data  = bytes[i];
      if (i > 0 && !busy_o) o.busy_bad = 1'b1;
      w = 0;
      while (!host_rx_ready && w < 50) begin
        @(posedge clk); #1; w++;
      end
      if (!host_rx_ready) begin
        o.timeout = 1'b1;
        host_rx_valid = 1'b0;
        return;
      end
      o.hs_stamp = cyc;
      @(posedge clk); #1;
    end
    host_rx_valid = 1'b0;
    host_rx_data  = 8'd0;

    if (!hdr[7]) begin
      w = 0;
      while (!debug_a_valid && w < 50) begin
        if (host_rx_ready) o.rx_leak = 1'b1;
        @(posedge clk); #1; w++;
      end
      if (!debug_a_valid) begin
        o.timeout = 1'b1;
        return;
      end
      o.a_pulse   = 1'b1;
      o.a_stamp   = cyc;
      o.a_opcode  = debug_a_opcode;
      o.a_param   = debug_a_param;
      o.a_size    = debug_a_size;
      o.a_mask    = debug_a_mask;
      o.a_source  = debug_a_source;
      o.a_address = debug_a_address;
      o.a_data    = debug_a_data;
      o.a_corrupt = debug_a_corrupt;
      for (int k = 0; k < a_dly; k++) begin
        @(posedge clk); #1;
        if (!debug_a_valid || debug_a_opcode !== o.a_opcode || debug_a_address !== o.a_address ||
            debug_a_data !== o.a_data || debug_a_size !== o.a_size || debug_a_mask !== o.a_mask ||
            debug_a_source !== o.a_source)
          o.a_unstable = 1'b1;
        if (host_rx_ready) o.rx_leak = 1'b1;
        if (!busy_o) o.busy_bad = 1'b1;
      end
      debug_a_ready = 1'b1;
      @(posedge clk); #1;
      debug_a_ready = 1'b0;
      o.a_valid_after   = debug_a_valid;
      o.d_ready_after_a = debug_d_ready;
      for (int k = 0; k < d_dly; k++) begin
        if (host_rx_ready) o.rx_leak = 1'b1;
        if (!busy_o) o.busy_bad = 1'b1;
        @(posedge clk); #1;
      end
      debug_d_valid   = 1'b1;
      debug_d_data    = rd;
      debug_d_denied  = den;
      debug_d_corrupt = cor;
      debug_d_opcode  = 3'($urandom_range(0, 7));
      debug_d_param   = 2'($urandom_range(0, 3));
      debug_d_size    = 4'($urandom_range(0, 15));
      debug_d_source  = TL_RS'($urandom_range(0, 15));
      w = 0;
      while (!debug_d_ready && w < 50) begin
        @(posedge clk); #1; w++;
      end
      if (!debug_d_ready) begin
        o.timeout = 1'b1;
        debug_d_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      debug_d_valid   = 1'b0;
      debug_d_data    = $urandom;
      debug_d_denied  = 1'b0;
      debug_d_corrupt = 1'b0;
      o.d_ready_after_d = debug_d_ready;
    end

    pend = 1'b0;
    got_first = 1'b0;
    pdata = 8'd0;
    w = 0;
    while (w < 200) begin
      if (host_rx_ready) break;
      if (debug_a_valid) o.a_pulse = 1'b1;
      if (!busy_o) o.busy_bad = 1'b1;
      if (!host_tx_valid) begin
        o.tx_gap = 1'b1;
      end else begin
        if (!got_first) begin
          got_first = 1'b1;
          o.tx_stamp = cyc;
        end
        if (pend && host_tx_data !== pdata) o.tx_unstable = 1'b1;
        host_tx_ready = tx_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (host_tx_ready) begin
          if (o.tx_n < 5) o.tx_bytes[8*o.tx_n +: 8] = host_tx_data;
          o.tx_n++;
          pend = 1'b0;
        end else begin
          pend  = 1'b1;
          pdata = host_tx_data;
        end
      end
      @(posedge clk); #1; w++;
    end
    host_tx_ready = 1'b0;
    if (!host_rx_ready) begin
      o.timeout = 1'b1;
    end else begin
      o.idle_stamp = cyc;
      o.busy_idle  = busy_o;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({host_rx_ready, host_tx_valid, debug_a_valid, debug_d_ready, busy_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: rx_rdy/tx_vld/a_vld/d_rdy/busy=%b want 00000",
               {host_rx_ready, host_tx_valid, debug_a_valid, debug_d_ready, busy_o});
    end
    total++;
    if ({host_tx_data, debug_a_opcode, debug_a_size, debug_a_source, debug_a_address,
         debug_a_mask, debug_a_data} !== '0) begin
      bad++;
      $display("FAIL reset_payload: tx_data=%h op=%h size=%h src=%h addr=%h mask=%h data=%h want all 0",
               host_tx_data, debug_a_opcode, debug_a_size, debug_a_source, debug_a_address,
               debug_a_mask, debug_a_data);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (host_rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_early: rx_ready=%b want 0 before first edge", host_rx_ready);
    end
    @(posedge clk); #1;
    total++;
    if (host_rx_ready !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rx_ready=%b busy=%b want 1 0", host_rx_ready, busy_o);
    end
  endtask

  task automatic test_write();
    obs_t o;
    int en;
    logic [39:0] eb;
    do_txn(8'h12, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0, 0, 0, 1'b0, o);
    model_tx(8'h12, 32'hCAFEF00D, 1'b0, 1'b0, en, eb);
    total++;
    if (o.timeout) begin bad++; $display("FAIL write_timeout: got timeout want none"); end
    total++;
    if (o.a_opcode !== 3'd0 || o.a_address !== 5'h12 || o.a_data !== 32'h12345678) begin
      bad++;
      $display("FAIL write_a: op=%h addr=%h data=%h want 0 12 12345678", o.a_opcode, o.a_address, o.a_data);
    end
    total++;
    if (o.a_mask !== 4'hF || o.a_size !== 4'd2 || o.a_param !== 3'd0 || o.a_corrupt !== 1'b0 ||
        o.a_source !== TL_RS'(SOURCE_ID)) begin
      bad++;
      $display("FAIL write_a_const: mask=%h size=%h param=%h corrupt=%b src=%h want F 2 0 0 %h",
               o.a_mask, o.a_size, o.a_param, o.a_corrupt, o.a_source, SOURCE_ID);
    end
    total++;
    if (o.tx_n != en || o.tx_bytes !== eb) begin
      bad++;
      $display("FAIL write_tx: n=%0d bytes=%h want n=%0d bytes=%h", o.tx_n, o.tx_bytes, en, eb);
    end
    total++;
    if (o.a_valid_after || !o.d_ready_after_a || o.d_ready_after_d) begin
      bad++;
      $display("FAIL write_hs: a_vld_after=%b d_rdy_after_a=%b d_rdy_after_d=%b want 0 1 0",
               o.a_valid_after, o.d_ready_after_a, o.d_ready_after_d);
    end
    total++;
    if (o.busy_bad || o.busy_idle || o.rx_leak) begin
      bad++;
      $display("FAIL write_busy: busy_bad=%b busy_idle=%b rx_leak=%b want 0 0 0", o.busy_bad, o.busy_idle, o.rx_leak);
    end
  endtask

  task automatic test_read();
    obs_t o;
    int en;
    logic [39:0] eb;
    do_txn(8'h43, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0, 0, 0, 1'b0, o);
    model_tx(8'h43, 32'hDEADBEEF, 1'b0, 1'b0, en, eb);
    total++;
    if (o.timeout || o.a_opcode !== 3'd4 || o.a_address !== 5'h03 || o.a_data !== 32'd0) begin
      bad++;
      $display("FAIL read_a: timeout=%b op=%h addr=%h data=%h want 0 4 03 0", o.timeout, o.a_opcode, o.a_address, o.a_data);
    end
    total++;
    if (o.tx_n != en || o.tx_bytes !== eb) begin
      bad++;
      $display("FAIL read_tx: n=%0d bytes=%h want n=%0d bytes=%h", o.tx_n, o.tx_bytes, en, eb);
    end
    total++;
    if (o.a_stamp - o.hs_stamp != 1 || o.tx_stamp - o.hs_stamp != 3 || o.idle_stamp - o.hs_stamp != 8) begin
      bad++;
      $display("FAIL read_latency: a=+%0d tx=+%0d idle=+%0d want +1 +3 +8",
               o.a_stamp - o.hs_stamp, o.tx_stamp - o.hs_stamp, o.idle_stamp - o.hs_stamp);
    end
    total++;
    if (o.tx_gap || o.rx_leak || o.busy_bad) begin
      bad++;
      $display("FAIL read_flow: gap=%b rx_leak=%b busy_bad=%b want 0 0 0", o.tx_gap, o.rx_leak, o.busy_bad);
    end
  endtask

  task automatic test_reserved();
    obs_t o;
    int en;
    logic [39:0] eb;
    logic [31:0] rd;
    do_txn(8'h80, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0, o);
    model_tx(8'h80, 32'd0, 1'b0, 1'b0, en, eb);
    total++;
    if (o.timeout || o.a_pulse) begin
      bad++;
      $display("FAIL reserved_no_a: timeout=%b a_pulse=%b want 0 0", o.timeout, o.a_pulse);
    end
    total++;
    if (o.tx_n != en || o.tx_bytes !== eb || o.tx_stamp - o.hs_stamp != 1) begin
      bad++;
      $display("FAIL reserved_tx: n=%0d bytes=%h lat=%0d want n=%0d bytes=%h lat=1",
               o.tx_n, o.tx_bytes, o.tx_stamp - o.hs_stamp, en, eb);
    end
    rd = $urandom;
    do_txn(8'h5F, 32'd0, rd, 1'b0, 1'b0, 0, 1, 1'b0, o);
    model_tx(8'h5F, rd, 1'b0, 1'b0, en, eb);
    total++;
    if (o.timeout || o.a_opcode !== 3'd4 || o.a_address !== 5'h1F || o.tx_n != en || o.tx_bytes !== eb) begin
      bad++;
      $display("FAIL reserved_next: timeout=%b op=%h addr=%h n=%0d bytes=%h want 0 4 1F n=%0d bytes=%h",
               o.timeout, o.a_opcode, o.a_address, o.tx_n, o.tx_bytes, en, eb);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    int en;
    logic [39:0] eb;
    logic [31:0] rd;
    logic [31:0] wd;
    rd = $urandom;
    do_txn(8'h4A, 32'd0, rd, 1'b0, 1'b0, 5, 2, 1'b1, o);
    model_tx(8'h4A, rd, 1'b0, 1'b0, en, eb);
    total++;
    if (o.timeout || o.a_unstable || o.a_address !== 5'h0A) begin
      bad++;
      $display("FAIL bp_read_a: timeout=%b unstable=%b addr=%h want 0 0 0A", o.timeout, o.a_unstable, o.a_address);
    end
    total++;
    if (o.tx_n != en || o.tx_bytes !== eb || o.tx_unstable || o.tx_gap) begin
      bad++;
      $display("FAIL bp_read_tx: n=%0d bytes=%h unstable=%b gap=%b want n=%0d bytes=%h 0 0",
               o.tx_n, o.tx_bytes, o.tx_unstable, o.tx_gap, en, eb);
    end
    total++;
    if (o.rx_leak) begin bad++; $display("FAIL bp_rx_stall: rx_ready seen high=%b want 0", o.rx_leak); end
    wd = $urandom;
    do_txn(8'h2C, wd, 32'hFFFFFFFF, 1'b0, 1'b0, 5, 0, 1'b1, o);
    model_tx(8'h2C, 32'hFFFFFFFF, 1'b0, 1'b0, en, eb);
    total++;
    if (o.timeout || o.a_unstable || o.a_data !== wd || o.a_address !== 5'h0C || o.tx_n != en || o.tx_bytes !== eb) begin
      bad++;
      $display("FAIL bp_write: timeout=%b unstable=%b data=%h addr=%h n=%0d bytes=%h want 0 0 %h 0C n=%0d %h",
               o.timeout, o.a_unstable, o.a_data, o.a_address, o.tx_n, o.tx_bytes, wd, en, eb);
    end
  endtask

  task automatic test_denied();
    obs_t o;
    int en;
    logic [39:0] eb;
    logic [31:0] rd;
    do_txn(8'h45, 32'd0, 32'd0, 1'b1, 1'b0, 0, 0, 1'b0, o);
    model_tx(8'h45, 32'd0, 1'b1, 1'b0, en, eb);
    total++;
    if (o.timeout || o.tx_n != en || o.tx_bytes !== eb) begin
      bad++;
      $display("FAIL denied_read: timeout=%b n=%0d bytes=%h want 0 n=%0d bytes=%h", o.timeout, o.tx_n, o.tx_bytes, en, eb);
    end
    rd = $urandom;
    do_txn(8'h46, 32'd0, rd, 1'b0, 1'b1, 1, 0, 1'b0, o);
    model_tx(8'h46, rd, 1'b0, 1'b1, en, eb);
    total++;
    if (o.timeout || o.tx_n != en || o.tx_bytes !== eb) begin
      bad++;
      $display("FAIL corrupt_read: timeout=%b n=%0d bytes=%h want 0 n=%0d bytes=%h", o.timeout, o.tx_n, o.tx_bytes, en, eb);
    end
    do_txn(8'h07, 32'h0BADF00D, rd, 1'b1, 1'b0, 0, 0, 1'b0, o);
    model_tx(8'h07, rd, 1'b1, 1'b0, en, eb);
    total++;
    if (o.timeout || o.tx_n != en || o.tx_bytes !== eb) begin
      bad++;
      $display("FAIL denied_write: timeout=%b n=%0d bytes=%h want 0 n=%0d bytes=%h", o.timeout, o.tx_n, o.tx_bytes, en, eb);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int en;
    logic [39:0] eb;
    logic [31:0] rd;
    host_rx_valid = 1'b1;
    host_rx_data  = 8'h41;
    @(posedge clk); #1;
    host_rx_valid = 1'b0;
    debug_a_ready = 1'b1;
    @(posedge clk); #1;
    debug_a_ready = 1'b0;
    total++;
    if (debug_d_ready !== 1'b1 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_setup: d_ready=%b busy=%b want 1 1", debug_d_ready, busy_o);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({debug_d_ready, busy_o, debug_a_valid, host_tx_valid, host_rx_ready} !== 5'b0) begin
      bad++;
      $display("FAIL midrst_drop: d_rdy/busy/a_vld/tx_vld/rx_rdy=%b want 00000",
               {debug_d_ready, busy_o, debug_a_valid, host_tx_valid, host_rx_ready});
    end
    debug_d_valid = 1'b1;
    debug_d_data  = 32'h11111111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    debug_d_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (host_tx_valid !== 1'b0 || host_rx_ready !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_after: tx_valid=%b rx_ready=%b busy=%b want 0 1 0", host_tx_valid, host_rx_ready, busy_o);
    end
    rd = $urandom;
    do_txn(8'h40, 32'd0, rd, 1'b0, 1'b0, 0, 0, 1'b0, o);
    model_tx(8'h40, rd, 1'b0, 1'b0, en, eb);
    total++;
    if (o.timeout || o.a_address !== 5'h00 || o.a_opcode !== 3'd4 || o.tx_n != en || o.tx_bytes !== eb) begin
      bad++;
      $display("FAIL midrst_read: timeout=%b addr=%h op=%h n=%0d bytes=%h want 0 00 4 n=%0d bytes=%h",
               o.timeout, o.a_address, o.a_opcode, o.tx_n, o.tx_bytes, en, eb);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int en;
    logic [39:0] eb;
    logic [7:0] hdr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic den;
    logic cor;
    for (int it = 0; it < 25; it++) begin
      hdr = 8'($urandom);
      wd  = $urandom;
      rd  = $urandom;
      den = ($urandom_range(0, 3) == 0);
      cor = ($urandom_range(0, 3) == 0);
      do_txn(hdr, wd, rd, den, cor, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), o);
      model_tx(hdr, rd, den, cor, en, eb);
      total++;
      if (o.timeout || o.a_pulse !== !hdr[7]) begin
        bad++;
        $display("FAIL rand_a_issue[%0d]: hdr=%h timeout=%b a_pulse=%b want 0 %b", it, hdr, o.timeout, o.a_pulse, !hdr[7]);
      end
      if (!hdr[7]) begin
        total++;
        if (o.a_opcode !== (hdr[6] ? 3'd4 : 3'd0) || o.a_address !== hdr[4:0] ||
            o.a_data !== (hdr[6] ? 32'd0 : wd) || o.a_unstable) begin
          bad++;
          $display("FAIL rand_a_fields[%0d]: hdr=%h op=%h addr=%h data=%h unstable=%b wd=%h",
                   it, hdr, o.a_opcode, o.a_address, o.a_data, o.a_unstable, wd);
        end
      end
      total++;
      if (o.tx_n != en || o.tx_bytes !== eb || o.tx_unstable || o.tx_gap || o.rx_leak || o.busy_bad || o.busy_idle) begin
        bad++;
        $display("FAIL rand_tx[%0d]: hdr=%h n=%0d bytes=%h flags(unst,gap,leak,busy,idle)=%b%b%b%b%b want n=%0d bytes=%h 00000",
                 it, hdr, o.tx_n, o.tx_bytes, o.tx_unstable, o.tx_gap, o.rx_leak, o.busy_bad, o.busy_idle, en, eb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_reserved();
    test_backpressure();
    test_denied();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
